// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done handshake and operand/result bundle for the divider
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Controller side: issues divides and collects results
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_sr;     // dividend shifting out the top, quotient bits shifting in the bottom
  logic [WIDTH-1:0] d_reg;    // captured divisor
  logic [WIDTH-1:0] r_reg;    // partial remainder
  logic [CW-1:0]    cnt;      // iterations left

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction one bit wider than the operands so a borrow shows up in the MSB
  always_comb begin
    trial  = {r_reg, q_sr[WIDTH-1]};
    diff   = trial - {1'b0, d_reg};
    r_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_next = {q_sr[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Control FSM, iteration datapath and registered result/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      q_sr            <= '0;
      d_reg           <= '0;
      r_reg           <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              q_sr            <= bus.dividend;
              d_reg           <= bus.divisor;
              r_reg           <= '0;
              cnt             <= CW'(WIDTH);
              bus.busy        <= 1'b1;
              bus.div_by_zero <= 1'b0;
              state           <= RUN;
            end else begin
              // Zero divisor completes immediately with saturated quotient
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_sr  <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Results are published only on the final iteration
            bus.quotient  <= q_next;
            bus.remainder <= r_next;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and sweep bench for seq_restoring_divider
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(4)) bus4 ();
  seq_restoring_divider_if #(.WIDTH(8)) bus8 ();

  seq_restoring_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  seq_restoring_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  // Issue one divide on the 4-bit unit from a negedge; returns at the negedge where done is seen.
  // lat counts edges after the accepting edge; bcnt counts busy samples before done.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output logic [3:0] q, output logic [3:0] r, output logic dz,
                      output int lat, output int bcnt);
    bus4.start = 1'b1; bus4.dividend = a; bus4.divisor = b;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!bus4.done && lat < 40) begin
      bcnt += int'(bus4.busy);
      @(negedge clk);
      lat++;
    end
    q = bus4.quotient; r = bus4.remainder; dz = bus4.div_by_zero;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] q, output logic [7:0] r, output logic dz,
                      output int lat);
    bus8.start = 1'b1; bus8.dividend = a; bus8.divisor = b;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    q = bus8.quotient; r = bus8.remainder; dz = bus8.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus4.quotient !== 4'd0) $display("FAIL reset_quotient got %0d want 0", bus4.quotient); else passed++;
    total++; if (bus4.remainder !== 4'd0) $display("FAIL reset_remainder got %0d want 0", bus4.remainder); else passed++;
    total++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus4.busy); else passed++;
    total++; if (bus4.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus4.done); else passed++;
    total++; if (bus4.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", bus4.div_by_zero); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] a_v [4] = '{4'd13, 4'd15, 4'd5, 4'd0};
    logic [3:0] b_v [4] = '{4'd3,  4'd1,  4'd7, 4'd9};
    logic [3:0] q_v [4] = '{4'd4,  4'd15, 4'd0, 4'd0};
    logic [3:0] r_v [4] = '{4'd1,  4'd0,  4'd5, 4'd0};
    logic [3:0] q, r;
    logic dz;
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      run4(a_v[i], b_v[i], q, r, dz, lat, bcnt);
      total++; if (lat !== 4) $display("FAIL basic_latency %0d/%0d got %0d want 4", a_v[i], b_v[i], lat); else passed++;
      total++; if (bcnt !== 4) $display("FAIL basic_busy_cycles %0d/%0d got %0d want 4", a_v[i], b_v[i], bcnt); else passed++;
      total++; if (q !== q_v[i]) $display("FAIL basic_quotient %0d/%0d got %0d want %0d", a_v[i], b_v[i], q, q_v[i]); else passed++;
      total++; if (r !== r_v[i]) $display("FAIL basic_remainder %0d/%0d got %0d want %0d", a_v[i], b_v[i], r, r_v[i]); else passed++;
      total++; if (dz !== 1'b0) $display("FAIL basic_dbz %0d/%0d got %b want 0", a_v[i], b_v[i], dz); else passed++;
      @(negedge clk);
      total++; if (bus4.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus4.done); else passed++;
    end
  endtask

  task automatic test_div_by_zero();
    logic [3:0] q, r;
    logic dz;
    int lat, bcnt;
    run4(4'd11, 4'd0, q, r, dz, lat, bcnt);
    total++; if (lat !== 0) $display("FAIL dbz_latency got %0d want 0", lat); else passed++;
    total++; if (bcnt !== 0) $display("FAIL dbz_busy_cycles got %0d want 0", bcnt); else passed++;
    total++; if (q !== 4'd15) $display("FAIL dbz_quotient got %0d want 15", q); else passed++;
    total++; if (r !== 4'd11) $display("FAIL dbz_remainder got %0d want 11", r); else passed++;
    total++; if (dz !== 1'b1) $display("FAIL dbz_flag got %b want 1", dz); else passed++;
    @(negedge clk);
    total++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) $display("FAIL dbz_after done=%b busy=%b want 0 0", bus4.done, bus4.busy); else passed++;
    total++; if (bus4.div_by_zero !== 1'b1) $display("FAIL dbz_hold got %b want 1", bus4.div_by_zero); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] q, r;
    logic dz;
    int e, first_done, ndone, lat, bcnt;
    bus4.start = 1'b1; bus4.dividend = 4'd14; bus4.divisor = 4'd4;
    @(negedge clk);
    bus4.start = 1'b0;
    e = 0; first_done = -1; ndone = 0;
    while (first_done < 0 && e < 40) begin
      if (e == 1) begin
        bus4.start = 1'b1; bus4.dividend = 4'd9; bus4.divisor = 4'd2;
      end else begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
      e++;
      if (bus4.done) begin ndone++; first_done = e; end
    end
    total++; if (first_done !== 4) $display("FAIL b2b_first_latency got %0d want 4", first_done); else passed++;
    total++; if (bus4.quotient !== 4'd3 || bus4.remainder !== 4'd2)
      $display("FAIL b2b_first_result got q=%0d r=%0d want q=3 r=2", bus4.quotient, bus4.remainder); else passed++;
    total++; if (bus4.div_by_zero !== 1'b0) $display("FAIL b2b_dbz_cleared got %b want 0", bus4.div_by_zero); else passed++;
    // Issue the next divide in the done cycle
    run4(4'd9, 4'd2, q, r, dz, lat, bcnt);
    total++; if (ndone !== 1) $display("FAIL b2b_done_count got %0d want 1", ndone); else passed++;
    total++; if (lat !== 4) $display("FAIL b2b_second_latency got %0d want 4", lat); else passed++;
    total++; if (q !== 4'd4 || r !== 4'd1) $display("FAIL b2b_second_result got q=%0d r=%0d want q=4 r=1", q, r); else passed++;
  endtask

  task automatic test_async_reset();
    logic [3:0] q, r;
    logic dz;
    int lat, bcnt, seen_done;
    bus4.start = 1'b1; bus4.dividend = 4'd12; bus4.divisor = 4'd5;
    @(negedge clk);
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus4.quotient !== 4'd0 || bus4.remainder !== 4'd0)
      $display("FAIL areset_results got q=%0d r=%0d want 0 0", bus4.quotient, bus4.remainder); else passed++;
    total++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.div_by_zero !== 1'b0)
      $display("FAIL areset_flags got busy=%b done=%b dbz=%b want 0 0 0", bus4.busy, bus4.done, bus4.div_by_zero); else passed++;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      seen_done += int'(bus4.done);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done += int'(bus4.done);
    end
    total++; if (seen_done !== 0) $display("FAIL areset_no_done got %0d pulses want 0", seen_done); else passed++;
    run4(4'd12, 4'd5, q, r, dz, lat, bcnt);
    total++; if (lat !== 4 || q !== 4'd2 || r !== 4'd2)
      $display("FAIL areset_resume got lat=%0d q=%0d r=%0d want 4 2 2", lat, q, r); else passed++;
  endtask

  task automatic test_sweep4();
    logic [3:0] q, r, a, b;
    logic dz;
    int lat, bcnt, want_lat, want_b;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4]; b = i[3:0];
      run4(a, b, q, r, dz, lat, bcnt);
      want_lat = (b == 0) ? 0 : 4;
      want_b   = (b == 0) ? 0 : 4;
      total++; if (lat !== want_lat || bcnt !== want_b)
        $display("FAIL sweep4_timing %0d/%0d got lat=%0d busy=%0d want %0d %0d", a, b, lat, bcnt, want_lat, want_b); else passed++;
      if (b == 0) begin
        total++; if (q !== 4'd15 || r !== a || dz !== 1'b1)
          $display("FAIL sweep4_zero %0d/0 got q=%0d r=%0d dbz=%b want 15 %0d 1", a, q, r, dz, a); else passed++;
      end else begin
        total++; if (q !== a / b || r !== a % b || dz !== 1'b0)
          $display("FAIL sweep4_result %0d/%0d got q=%0d r=%0d dbz=%b want %0d %0d 0", a, b, q, r, dz, a / b, a % b); else passed++;
        total++; if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b)
          $display("FAIL sweep4_identity %0d/%0d got q=%0d r=%0d", a, b, q, r); else passed++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep8();
    logic [7:0] q, r, a, b;
    logic dz;
    int lat;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i == 1) begin a = 8'd255; b = 8'd1; end
      if (i == 2) begin a = 8'd7;   b = 8'd255; end
      run8(a, b, q, r, dz, lat);
      if (b == 0) begin
        total++; if (lat !== 0 || q !== 8'd255 || r !== a || dz !== 1'b1)
          $display("FAIL sweep8_zero %0d/0 got lat=%0d q=%0d r=%0d dbz=%b want 0 255 %0d 1", a, lat, q, r, dz, a); else passed++;
      end else begin
        total++; if (lat !== 8 || q !== a / b || r !== a % b || dz !== 1'b0)
          $display("FAIL sweep8_result %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want 8 %0d %0d 0", a, b, lat, q, r, dz, a / b, a % b); else passed++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
    bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
    test_reset();
    test_basic();
    test_div_by_zero();
    test_back_to_back();
    test_async_reset();
    test_sweep4();
    test_sweep8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Unsigned sequential restoring divider. It is the inverse-operation companion to the team's combinational add/subtract datapath.
- Computes quotient and remainder by repeated trial subtraction, one bit per clock, using an internal WIDTH+1-bit subtractor.
- Sits behind a start/busy/done handshake so a controller can issue divides and collect results.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a divide; sampled only while idle
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
- quotient  output  WIDTH  unsigned quotient; registered
- remainder  output  WIDTH  unsigned remainder; registered
- busy  output  1  high while an accepted divide is iterating
- done  output  1  single-cycle pulse: quotient/remainder/div_by_zero are valid
- div_by_zero  output  1  set with done when the captured divisor was zero

Behaviour:
- Reset (async, rst=1): state IDLE. quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, iteration counter=0. Reset asserted mid-operation aborts it immediately with no done pulse. Operation resumes on the first clock edge after rst deasserts.
- State machine: IDLE, RUN.
  - IDLE -> RUN: on an edge with start=1 and divisor!=0. Capture dividend into shift register Q, divisor into D, partial remainder R=0, counter=WIDTH. busy=1, done=0, div_by_zero=0.
  - IDLE -> IDLE, zero divisor: on an edge with start=1 and divisor==0. quotient=all ones, remainder=dividend, div_by_zero=1, done=1 for exactly one cycle. busy stays 0.
  - RUN, each edge performs one iteration:
    - T = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits); diff = T - {1'b0, D} (WIDTH+1 bits).
    - If diff MSB=0: R=diff[WIDTH-1:0], shift 1 into Q LSB.
    - Else (restore): R=T[WIDTH-1:0], shift 0 into Q LSB.
    - Q shifts left by one; counter decrements.
  - RUN -> IDLE: on the edge where counter goes 1->0. On that same edge quotient=final Q, remainder=final R, busy=0, done=1.
- done: high for exactly one cycle, then cleared on the next edge unless a new zero-divisor start fires.
- Latency:
  - Start accepted at edge k -> done visible after edge k+WIDTH. busy is high from after edge k through edge k+WIDTH-1.
  - Zero divisor -> done visible after edge k.
- Back-to-back operation: start asserted in the cycle where done=1 is accepted (state is IDLE), giving one divide every WIDTH+1 cycles maximum.
- start while busy=1: ignored. No capture, no queueing, no effect on the running divide.
- Operand changes after the accepting edge: ignored.
- quotient, remainder and div_by_zero: hold their last values until the next completion. div_by_zero clears when a nonzero-divisor start is accepted.
- Arithmetic identity on every non-zero completion: quotient*divisor+remainder == dividend, with remainder < divisor. No overflow is possible; the trial subtraction is WIDTH+1 bits wide so that a borrow is detected at the MSB.
- Quotient and remainder registers are never partially updated mid-run; intermediate Q/R are internal only.

Test Plan:
- WIDTH=4, reset then start with dividend=13, divisor=3 -> busy high 4 cycles; done after edge k+4 with quotient=4, remainder=1, div_by_zero=0; done low the next cycle.
- dividend=15, divisor=1 -> quotient=15, remainder=0. dividend=5, divisor=7 -> quotient=0, remainder=5. dividend=0, divisor=9 -> quotient=0, remainder=0.
- dividend=11, divisor=0 -> done and div_by_zero=1 one cycle after the accepting edge; quotient=15, remainder=11; busy never asserts.
- Start 14/4; pulse start with 9/2 two cycles later while busy -> result is quotient=3, remainder=2 only, a single done pulse. Then start 9/2 in the done cycle -> quotient=4, remainder=1 exactly 4 edges later.
- Start 12/5, assert rst asynchronously (off clock edge) after 2 iterations -> all outputs 0 immediately, no done. After release, 12/5 gives quotient=2, remainder=2.
- Exhaustive sweep for WIDTH=4, all 256 operand pairs against a reference model, checking latency, the arithmetic identity and div_by_zero. Repeat as a random sweep at WIDTH=8.
